// File: rtl/rot_cmd_queue.sv
// rtl/rot_cmd_queue.sv - request FIFO and registered result stage for the 8-bit left-rotator
// Define ROT_CMD_RIGHT_EN to honour in_dir; otherwise every request rotates left.
module rot_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic [2:0]               in_shift,
  input  logic                     in_dir,
  output logic [7:0]               rot_x,
  output logic [2:0]               rot_shift,
  input  logic [7:0]               rot_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef ROT_CMD_RIGHT_EN
  localparam int EW = 12;
`else
  localparam int EW = 11;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;

  logic          empty_w;
  logic          push_w;
  logic          load_w;
  logic [EW-1:0] head_w;
  logic [EW-1:0] entry_w;
  logic [2:0]    head_shift_w;

`ifdef ROT_CMD_RIGHT_EN
  assign entry_w = {in_dir, in_shift, in_data};
`else
  logic unused_dir;
  assign unused_dir = in_dir;
  assign entry_w    = {in_shift, in_data};
`endif

  assign empty_w      = (count_q == '0);
  assign in_ready     = (count_q < CW'(DEPTH));
  assign push_w       = in_valid && in_ready;
  assign load_w       = !empty_w && (!out_valid_q || out_ready);
  assign head_w       = mem_q[rd_ptr_q];
  assign head_shift_w = head_w[10:8];

  assign rot_x = empty_w ? 8'd0 : head_w[7:0];
`ifdef ROT_CMD_RIGHT_EN
  // Right by s equals left by (8 - s) mod 8, i.e. the 3-bit negation of s.
  assign rot_shift = empty_w ? 3'd0 : (head_w[11] ? (3'd0 - head_shift_w) : head_shift_w);
`else
  assign rot_shift = empty_w ? 3'd0 : head_shift_w;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (load_w) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_data_d  = rot_y;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push_w, load_w})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_w && !flush) begin
      mem_q[wr_ptr_q] <= entry_w;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_rot_cmd_queue.sv
// tb/tb_rot_cmd_queue.sv - self-checking bench for rot_cmd_queue
// Honours ROT_CMD_RIGHT_EN when it is defined for the build.
module tb_rot_cmd_queue;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic [2:0]             in_shift;
  logic                   in_dir;
  logic [7:0]             rot_x;
  logic [2:0]             rot_shift;
  logic [7:0]             rot_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic [$clog2(DEPTH):0] count;

  int errors = 0;
  int checks = 0;

  rot_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .in_dir(in_dir),
    .rot_x(rot_x), .rot_shift(rot_shift), .rot_y(rot_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] t;
    t = {x, x} << s;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] t;
    t = {x, x} >> s;
    return t[7:0];
  endfunction

  // Stand-in for the external combinational rotator
  assign rot_y = rotl(rot_x, rot_shift);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] s;
    logic       r;
  } ent_t;

  ent_t       mq[$];
  bit         m_ov;
  logic [7:0] m_od;

  function automatic logic [7:0] m_result(input ent_t e);
`ifdef ROT_CMD_RIGHT_EN
    return e.r ? rotr(e.d, e.s) : rotl(e.d, e.s);
`else
    return rotl(e.d, e.s);
`endif
  endfunction

  function automatic logic [2:0] m_rot_shift();
    if (mq.size() == 0) return 3'd0;
`ifdef ROT_CMD_RIGHT_EN
    if (mq[0].r) return 3'((8 - int'(mq[0].s)) % 8);
`endif
    return mq[0].s;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_od = 8'd0;
  endtask

  task automatic model_step(input bit f, input bit iv, input logic [7:0] d,
                            input logic [2:0] s, input bit r, input bit ordy);
    bit rdy;
    bit ld;
    ent_t e;
    rdy = (mq.size() < DEPTH);
    ld  = (mq.size() != 0) && (!m_ov || ordy);
    if (f) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (ld) begin
        m_od = m_result(mq[0]);
        void'(mq.pop_front());
        m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (iv && rdy) begin
        e.d = d; e.s = s; e.r = r;
        mq.push_back(e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    chk("m_count",     32'(count),     32'(mq.size()));
    chk("m_out_valid", 32'(out_valid), 32'(m_ov));
    chk("m_out_data",  32'(out_data),  32'(m_od));
    chk("m_rot_x",     32'(rot_x),     32'((mq.size() != 0) ? mq[0].d : 8'd0));
    chk("m_rot_shift", 32'(rot_shift), 32'(m_rot_shift()));
  endtask

  // Called at a point 1 time unit after a rising edge
  task automatic cycle(input bit f, input bit iv, input logic [7:0] d,
                       input logic [2:0] s, input bit r, input bit ordy);
    flush = f; in_valid = iv; in_data = d; in_shift = s; in_dir = r; out_ready = ordy;
    model_step(f, iv, d, s, r, ordy);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit         f;
    bit         iv;
    logic [7:0] d;
    logic [2:0] s;
    bit         ordy;
    bit         e_ov;
    logic [7:0] e_od;
    int         e_cnt;
    bit         e_rdy;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit f, bit iv, logic [7:0] d, logic [2:0] s, bit ordy,
                              bit e_ov, logic [7:0] e_od, int e_cnt, bit e_rdy);
    vec_t v;
    v.f = f; v.iv = iv; v.d = d; v.s = s; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(0, 1, 8'h81, 3'd1, 1, 0, 8'h00, 1, 1);
    tbl[1]  = mk(0, 0, 8'h00, 3'd0, 1, 1, 8'h03, 0, 1);
    tbl[2]  = mk(0, 0, 8'h00, 3'd0, 1, 0, 8'h03, 0, 1);
    tbl[3]  = mk(0, 1, 8'h01, 3'd1, 0, 0, 8'h03, 1, 1);
    tbl[4]  = mk(0, 1, 8'h02, 3'd1, 0, 1, 8'h02, 1, 1);
    tbl[5]  = mk(0, 1, 8'h03, 3'd1, 0, 1, 8'h02, 2, 1);
    tbl[6]  = mk(0, 1, 8'h04, 3'd1, 0, 1, 8'h02, 3, 1);
    tbl[7]  = mk(0, 1, 8'h05, 3'd1, 0, 1, 8'h02, 4, 0);
    tbl[8]  = mk(0, 1, 8'h06, 3'd1, 0, 1, 8'h02, 4, 0);
    tbl[9]  = mk(0, 0, 8'h00, 3'd0, 1, 1, 8'h04, 3, 1);
    tbl[10] = mk(0, 0, 8'h00, 3'd0, 1, 1, 8'h06, 2, 1);
    tbl[11] = mk(0, 0, 8'h00, 3'd0, 1, 1, 8'h08, 1, 1);
    tbl[12] = mk(0, 0, 8'h00, 3'd0, 1, 1, 8'h0A, 0, 1);
    tbl[13] = mk(0, 0, 8'h00, 3'd0, 1, 0, 8'h0A, 0, 1);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    in_shift = 3'd0; in_dir = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_rot_x",     32'(rot_x),     32'd0);
    chk("rst_rot_shift", 32'(rot_shift), 32'd0);
    rst = 1'b0;

    // Left rotate, backpressure fill and in-order drain
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].s, 1'b0, tbl[i].ordy);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i),  32'(out_data),  32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_count", i),     32'(count),     32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_rdy));
    end

    // Right rotate requests
    cycle(0, 1, 8'h81, 3'd1, 1'b1, 1);
`ifdef ROT_CMD_RIGHT_EN
    chk("right_rot_shift", 32'(rot_shift), 32'd7);
    cycle(0, 1, 8'h5A, 3'd0, 1'b1, 1);
    chk("right_out_c0", 32'(out_data), 32'hC0);
    cycle(0, 0, 8'h00, 3'd0, 1'b0, 1);
    chk("right_out_5a", 32'(out_data), 32'h5A);
`else
    chk("dirign_rot_shift", 32'(rot_shift), 32'd1);
    cycle(0, 0, 8'h00, 3'd0, 1'b0, 1);
    chk("dirign_out_03", 32'(out_data), 32'h03);
`endif
    cycle(0, 0, 8'h00, 3'd0, 1'b0, 1);

    // Full FIFO with output held: pop without push, then push accepted next cycle
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h10 + i), 3'd2, 1'b0, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count",    32'(count),    32'd4);
    cycle(0, 1, 8'h77, 3'd3, 1'b0, 1);
    chk("pp_count",    32'(count),    32'd3);
    chk("pp_in_ready", 32'(in_ready), 32'd1);
    cycle(0, 1, 8'h77, 3'd3, 1'b0, 0);
    chk("pp_push_count", 32'(count), 32'd4);
    cycle(0, 0, 8'h00, 3'd0, 1'b0, 1);
    chk("pre_flush_count", 32'(count), 32'd3);

    // Flush with a queued backlog and a held result; flush-cycle push dropped
    cycle(1, 1, 8'hEE, 3'd1, 1'b0, 0);
    chk("flush_count",     32'(count),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    cycle(0, 0, 8'h00, 3'd0, 1'b0, 1);
    chk("flush_drop", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'h21 + i), 3'd5, 1'b0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count",     32'(count),     32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 1, 8'hF0, 3'd4, 1'b0, 1);
    cycle(0, 0, 8'h00, 3'd0, 1'b0, 1);
    chk("post_rst_out", 32'(out_data), 32'h0F);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
            8'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
